// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: stage control encodings
// and the canonical NOP instruction used to build flush payloads.
package pipe_stage_elastic_pkg;

    // Stage control; any encoding other than GO or FLUSH behaves as HOLD.
    typedef enum logic [1:0] {
        CTRL_HOLD  = 2'b00,
        CTRL_GO    = 2'b01,
        CTRL_FLUSH = 2'b10
    } stage_ctrl_e;

    // Canonical no-op instruction (addi x0, x0, 0) for ID/EX flush payloads.
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flop plus W-bit payload register.
// Flush invalidates and reloads FLUSH_VAL; load fills; drop only invalidates.
module pipe_slot #(
    parameter int            W         = 64,
    parameter logic [W-1:0]  FLUSH_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    // Entry state: flush beats load beats drop; payload is kept on drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= FLUSH_VAL;
        end else if (flush) begin
            valid_reg <= 1'b0;
            data_reg  <= FLUSH_VAL;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (drop) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with GO/FLUSH/HOLD control and a
// saturating backpressure counter. Define PIPE_STAGE_SKID_EN to add a skid
// entry so in_ready comes straight from a flop instead of from out_ready.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int            W         = 64,
    parameter logic [W-1:0]  FLUSH_VAL = '0,
    parameter int            CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ctrl,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       level,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stall_cnt
);

    logic         go;
    logic         flush;
    logic         accept;
    logic         emit;
    logic         main_valid;
    logic [W-1:0] main_data;
    logic         main_load;
    logic         main_drop;
    logic [W-1:0] main_load_data;

    assign go    = (ctrl == CTRL_GO);
    assign flush = (ctrl == CTRL_FLUSH);

    // HOLD and FLUSH both mask the handshake combinationally.
    assign out_valid = go & main_valid;
    assign out_data  = main_data;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    pipe_slot #(.W(W), .FLUSH_VAL(FLUSH_VAL)) u_main (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (main_load),
        .drop      (main_drop),
        .load_data (main_load_data),
        .valid     (main_valid),
        .data      (main_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         skid_load;
    logic         skid_drop;

    // in_ready depends only on the skid flop, breaking the out_ready path.
    assign in_ready = go & ~skid_valid;
    assign level    = {1'b0, main_valid} + {1'b0, skid_valid};

    pipe_slot #(.W(W), .FLUSH_VAL(FLUSH_VAL)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (skid_load),
        .drop      (skid_drop),
        .load_data (in_data),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    // Steering: skid refills main on emit; accepts go to skid only when main is stuck.
    always_comb begin
        main_load      = 1'b0;
        main_drop      = 1'b0;
        main_load_data = in_data;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        if (emit) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_load_data = skid_data;
                skid_drop      = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_drop = 1'b1;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_load = 1'b1;
            end else begin
                main_load = 1'b1;
            end
        end
    end
`else
    // Single entry: a full stage still accepts when downstream drains it.
    assign in_ready = go & (~main_valid | out_ready);
    assign level    = {1'b0, main_valid};

    // Steering: every accept refills main; an emit without refill empties it.
    always_comb begin
        main_load      = accept;
        main_drop      = emit & ~accept;
        main_load_data = in_data;
    end
`endif

    logic [CNT_W-1:0] stall_cnt_reg;

    // Backpressure counter: clear wins, otherwise saturating increment on GO stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (clr_stats) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (W=32, FLUSH_VAL=NOP, CNT_W=2).
// A queue-based reference model runs alongside directed tables, hand-written
// corner sequences and a randomized phase.
module tb_pipe_stage_elastic;
    import pipe_stage_elastic_pkg::*;

    localparam int W     = 32;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = 3;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clk;
    logic             rst;
    logic [1:0]       ctrl;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       level;
    logic             clr_stats;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_elastic #(.W(W), .FLUSH_VAL(NOP), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .clr_stats (clr_stats),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered contents of the stage, last payload seen on
    // out_data, and the stall count.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    int           m_cnt;
    logic         saw_c;
    int           n_emit;

    // Values sampled from the DUT in the most recent cycle.
    logic         s_ov, s_ir;
    logic [W-1:0] s_od;
    logic [1:0]   s_lvl;
    logic [CNT_W-1:0] s_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = NOP;
        m_cnt  = 0;
    endtask

    // One clock cycle: drive at posedge+1, compare at the falling edge,
    // then advance the model at the rising edge.
    task automatic cycle(input logic [1:0] c, input logic iv, input logic [W-1:0] d,
                         input logic ordy, input logic clr);
        logic         go, e_ov, e_ir;
        logic [W-1:0] e_od;
        ctrl = c; in_valid = iv; in_data = d; out_ready = ordy; clr_stats = clr;
        go   = (c == CTRL_GO);
        e_ov = go && (mq.size() > 0);
        if (CAP == 2) e_ir = go && (mq.size() < 2);
        else          e_ir = go && ((mq.size() == 0) || ordy);
        e_od = (mq.size() > 0) ? mq[0] : m_last;
        #4;
        s_ov = out_valid; s_ir = in_ready; s_od = out_data; s_lvl = level; s_cnt = stall_cnt;
        chk("model_out_valid", 64'(out_valid), 64'(e_ov));
        chk("model_in_ready",  64'(in_ready),  64'(e_ir));
        chk("model_out_data",  64'(out_data),  64'(e_od));
        chk("model_level",     64'(level),     64'(mq.size()));
        chk("model_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (out_valid && ordy) begin
            n_emit++;
            if (out_data == 32'h0000_000C) saw_c = 1'b1;
        end
        @(posedge clk);
        if (c == CTRL_FLUSH) begin
            mq.delete();
            m_last = NOP;
        end else if (go) begin
            if (e_ov && ordy) void'(mq.pop_front());
            if (iv && e_ir) mq.push_back(d);
            if (mq.size() > 0) m_last = mq[0];
        end
        if (clr) m_cnt = 0;
        else if (e_ov && !ordy && m_cnt < CNT_MAX) m_cnt++;
        #1;
    endtask

    typedef struct {
        logic [1:0]   c;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         ov;
        logic         ir;
        logic [W-1:0] od;
        logic [1:0]   lvl;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int r;
        logic [1:0] rc;
        // Stream vectors: 0x1..0x8 in, each out one cycle later.
        for (int i = 0; i < 10; i++) begin
            tbl[i].c    = CTRL_GO;
            tbl[i].iv   = (i < 8);
            tbl[i].d    = (i < 8) ? W'(i + 1) : '0;
            tbl[i].ordy = 1'b1;
            tbl[i].ov   = (i >= 1 && i <= 8);
            tbl[i].ir   = 1'b1;
            tbl[i].od   = (i == 0) ? NOP : ((i <= 8) ? W'(i) : W'(8));
            tbl[i].lvl  = (i >= 1 && i <= 8) ? 2'd1 : 2'd0;
            tbl[i].cnt  = '0;
        end

        saw_c = 1'b0; n_emit = 0;
        rst = 1'b0; ctrl = CTRL_GO; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clr_stats = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Stream (table driven); first vector also covers reset state.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].c, tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
            chk($sformatf("stream%0d_ov", i),  64'(s_ov),  64'(tbl[i].ov));
            chk($sformatf("stream%0d_ir", i),  64'(s_ir),  64'(tbl[i].ir));
            chk($sformatf("stream%0d_od", i),  64'(s_od),  64'(tbl[i].od));
            chk($sformatf("stream%0d_lvl", i), 64'(s_lvl), 64'(tbl[i].lvl));
            chk($sformatf("stream%0d_cnt", i), 64'(s_cnt), 64'(tbl[i].cnt));
        end
        chk("stream_emits", 64'(n_emit), 64'd8);
        $display("stream done: emits=%0d", n_emit);

        // Backpressure: accept 0xA, 0xB then stall three cycles.
        cycle(CTRL_GO, 1'b1, 32'hA, 1'b0, 1'b0);
        cycle(CTRL_GO, 1'b1, 32'hB, 1'b0, 1'b0);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(CTRL_GO, 1'b1, 32'hE, 1'b0, 1'b0);
        chk("bp_full_in_ready", 64'(s_ir), 64'd0);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_level", 64'(s_lvl), 64'd2);
        chk("bp_in_ready", 64'(s_ir), 64'd0);
`else
        chk("bp_level", 64'(s_lvl), 64'd1);
        chk("bp_in_ready", 64'(s_ir), 64'd1);
`endif
        chk("bp_stall_cnt", 64'(s_cnt), 64'd3);
        chk("bp_first", 64'(s_od), 64'hA);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_second_ov", 64'(s_ov), 64'd1);
        chk("bp_second", 64'(s_od), 64'hB);
        chk("bp_release_ir", 64'(s_ir), 64'd1);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b1, 1'b0);
`endif
        chk("bp_drained", 64'(s_ov), 64'd0);
        $display("backpressure done: cnt=%0d", s_cnt);

        // Flush from full, with 0xC offered and clr_stats together.
        cycle(CTRL_GO, 1'b1, 32'h21, 1'b0, 1'b0);
        cycle(CTRL_GO, 1'b1, 32'h22, 1'b0, 1'b0);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(CTRL_FLUSH, 1'b1, 32'hC, 1'b1, 1'b1);
        chk("flush_ov", 64'(s_ov), 64'd0);
        chk("flush_ir", 64'(s_ir), 64'd0);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_after_ov", 64'(s_ov), 64'd0);
        chk("flush_after_lvl", 64'(s_lvl), 64'd0);
        chk("flush_after_od", 64'(s_od), 64'(NOP));
        chk("flush_clr_cnt", 64'(s_cnt), 64'd0);
        $display("flush done: level=%0d data=%0h", s_lvl, s_od);

        // Hold four cycles with 0xD in main.
        cycle(CTRL_GO, 1'b1, 32'hD, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rc = (i % 2 == 0) ? 2'b00 : 2'b11;
            cycle(rc, 1'b1, 32'hEE, 1'b0, 1'b0);
            chk($sformatf("hold%0d_ov", i), 64'(s_ov), 64'd0);
            chk($sformatf("hold%0d_ir", i), 64'(s_ir), 64'd0);
            chk($sformatf("hold%0d_cnt", i), 64'(s_cnt), 64'd0);
        end
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("hold_resume_ov", 64'(s_ov), 64'd1);
        chk("hold_resume_od", 64'(s_od), 64'hD);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("hold_once", 64'(s_ov), 64'd0);
        $display("hold done");

        // Saturation and clear with CNT_W=2.
        cycle(CTRL_GO, 1'b1, 32'h31, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(CTRL_GO, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("sat_cnt", 64'(s_cnt), 64'd3);
        cycle(CTRL_GO, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("sat_clr", 64'(s_cnt), 64'd0);
        chk("sat_emit", 64'(s_od), 64'h31);
        $display("saturation done");

        // Asynchronous reset between edges with one entry held.
        cycle(CTRL_GO, 1'b1, 32'h41, 1'b0, 1'b0);
        in_valid = 1'b0;
        #5 rst = 1'b0;
        #1;
        chk("arst_ov", 64'(out_valid), 64'd0);
        chk("arst_lvl", 64'(level), 64'd0);
        chk("arst_od", 64'(out_data), 64'(NOP));
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        $display("async reset done");

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 82)      rc = CTRL_GO;
            else if (r < 89) rc = CTRL_FLUSH;
            else if (r < 95) rc = 2'b00;
            else             rc = 2'b11;
            cycle(rc, 1'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 29) == 0));
        end
        $display("random done: emits=%0d", n_emit);

        chk("flushed_c_never_emitted", 64'(saw_c), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline-stage register that generalises the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries an opaque payload of configurable width under a valid/ready handshake. It keeps the existing global stage control (GO / FLUSH / HOLD) with fixed precedence and optionally adds a skid entry so `in_ready` is registered. A saturating stall counter supports pipeline performance debug.

## Interface
Parameters:
- `W`, 64: payload width in bits; legal range 1–1024.
- `FLUSH_VAL`, `{W{1'b0}}`: payload value loaded on reset and on flush. ID/EX instances put `NOP` in the instruction field.
- `CNT_W`, 16: stall counter width; legal range 1–32.

Ports:
- `clk` in 1: the single clock; every flop is rising-edge.
- `rst` in 1: reset is asynchronous and active-low.
- `ctrl` in 2: stage control, encodings `GO` / `FLUSH` from constants.vh. Any other value means HOLD.
- `in_valid` in 1: upstream holds a payload.
- `in_ready` out 1: stage accepts this cycle.
- `in_data` in W: upstream payload.
- `out_valid` out 1: stage presents a payload.
- `out_ready` in 1: downstream accepts this cycle.
- `out_data` out W: presented payload.
- `level` out 2: occupied entries, 0..1 without skid, 0..2 with skid.
- `clr_stats` in 1: synchronous clear of `stall_cnt`.
- `stall_cnt` out CNT_W: saturating count of backpressure cycles.

## Operation
- Transfer rules:
  - Accept means `in_valid & in_ready` at the edge.
  - Emit means `out_valid & out_ready` at the edge.
  - FIFO order is strict: no reordering and no duplication.
- Control precedence is FLUSH > HOLD > handshake. It is sampled every cycle.
- GO:
  - Normal elastic operation.
  - Accept and emit may occur in the same cycle.
- HOLD:
  - `in_ready` = 0 and `out_valid` = 0, both combinationally masked.
  - Entries, payloads and `level` are frozen.
  - `stall_cnt` does not increment.
- FLUSH:
  - `in_ready` = 0 and `out_valid` = 0 during the flush cycle.
  - At the edge, all entries go invalid, payload registers load `FLUSH_VAL`, and `level` becomes 0.
  - An `in_valid` presented in the flush cycle is dropped, not accepted.
- Entry structure without skid:
  - One entry, the main entry.
  - `in_ready` = `~main_valid | out_ready`, a combinational path from downstream.
- Entry structure with skid:
  - Two entries, main and skid. `in_ready` = `~skid_valid`, taken directly from a flop.
  - If an accept happens while main is full and not emitting, the data goes to skid.
  - When main emits, skid moves into main on the same edge.
  - If skid is empty, the accepted data (if any) loads main instead.
- `out_data` is always `main_data`. When `out_valid` = 0, it shows the last held value or `FLUSH_VAL`.
- `stall_cnt` behaviour:
  - Increments when `ctrl`=GO and `out_valid`=1 and `out_ready`=0.
  - Saturates at all-ones.
  - `clr_stats` wins over increment and loads 0.

## Timing
- Reset values: `out_valid` 0, `in_ready` 1 (GO, empty), `out_data` = `FLUSH_VAL`, skid data = `FLUSH_VAL`, `level` 0, `stall_cnt` 0.
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Latency: payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N; it is emittable at edge N+1.
- Throughput is 1 payload per cycle under continuous `out_ready`, in both configurations.
- Full boundaries:
  - Without skid: full with `out_ready`=1 still accepts, so the stage is pass-through.
  - With skid: `level`=2 forces `in_ready`=0 until the cycle after an emit.
- Empty boundary: `level`=0 with `in_valid`=1 and GO loads main; no emit is possible that cycle.
- Simultaneous FLUSH and `clr_stats`: both take effect.
- Return from HOLD: resumes with identical state; nothing is lost or repeated.
- Counter boundary: `stall_cnt` at all-ones plus a stall cycle stays all-ones.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`.
- Defined: skid entry is present, `in_ready` is registered, `level` ranges 0..2.
- Undefined: single entry, `in_ready` depends combinationally on `out_ready`, `level` is 0..1, and `level[1]` is tied 0.
- Port list is identical in both configurations.

## Structure
- constants.vh holds `GO`, `FLUSH` and `HOLD` (the catch-all encoding), plus `NOP` for callers building `FLUSH_VAL`.
- No new package contents are needed.
- Natural sub-module: `pipe_slot` (valid flop + W-bit payload register with load/clear, reset to `FLUSH_VAL`).
  - Instantiated once for main.
  - Instantiated a second time for skid under `PIPE_STAGE_SKID_EN`.
- Top level holds the control mux, the handshake logic and the stall counter.

## Test plan
- Stream: GO, `out_ready`=1, inputs 0x1..0x8 on consecutive cycles -> outputs 0x1..0x8 one cycle later, 8 consecutive emits, `stall_cnt`=0.
- Backpressure:
  - Setup: skid on; accept 0xA, 0xB; drop `out_ready` for 3 cycles.
  - Expected: `level`=2, `in_ready`=0, `stall_cnt`=3.
  - On release, emits 0xA then 0xB, then `in_ready`=1.
- Flush:
  - Setup: `level`=2, `FLUSH_VAL`=NOP; FLUSH for 1 cycle with `in_valid`=1 and data 0xC.
  - Expected: `out_valid`=0, `level`=0, `out_data`=NOP; 0xC is never emitted.
- Hold: HOLD for 4 cycles with 0xD held in main -> `out_valid`=0, `in_ready`=0, `stall_cnt` unchanged; GO then emits 0xD once.
- Saturation and clear: `CNT_W`=2 with 5 stall cycles -> `stall_cnt`=3; `clr_stats` together with a stall cycle -> 0.
- Async reset mid-transfer: pulse `rst` low between edges with `level`=1 -> immediately `out_valid`=0, `level`=0, `out_data`=`FLUSH_VAL`.
